listc3r3_matmult_arb: RTL

Two-port round-robin arbiter and sequencer that shares one `listc3r3_matmult` 3x3 signed 64-bit matrix-multiply core between two requesters. It latches a granted requester's A/B operands and drives the core's ready/accept handshake. It captures C into a per-requester result register and holds it there until that requester accepts it. It sits between the requesters and the core; the core uses the same `clk`/`rst`.

---
 rtl/listc3r3_matmult_arb.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/listc3r3_matmult_arb.sv
// Two-port round-robin arbiter/sequencer sharing one listc3r3_matmult core.
// Define MATMULT_ARB_TIMEOUT_EN to enable the WAIT-state watchdog and the err flag.
module listc3r3_matmult_arb #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_ready,
  input  logic [575:0] req0_in_a,
  input  logic [575:0] req0_in_b,
  output logic         req0_ack,
  output logic         req0_valid,
  input  logic         req0_accept,
  output logic [575:0] req0_out_c,
  input  logic         req1_ready,
  input  logic [575:0] req1_in_a,
  input  logic [575:0] req1_in_b,
  output logic         req1_ack,
  output logic         req1_valid,
  input  logic         req1_accept,
  output logic [575:0] req1_out_c,
  output logic         mm_ready,
  output logic         mm_accept,
  input  logic         mm_valid,
  output logic [575:0] mm_in_a,
  output logic [575:0] mm_in_b,
  input  logic [575:0] mm_out_c,
  output logic         err
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ACK   = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  state_t state_r;
  state_t state_nxt_s;
  logic   last_r;
  logic   owner_r;
  logic   elig0_s;
  logic   elig1_s;
  logic   pick1_s;
  logic   arb_s;
  logic   gnt0_s;
  logic   gnt1_s;
  logic   capture_s;
  logic   timeout_s;

  // Eligibility and round-robin choice; a held result blocks its owner.
  always_comb begin
    elig0_s = req0_ready & ~req0_valid;
    elig1_s = req1_ready & ~req1_valid;
    pick1_s = elig1_s & (~elig0_s | ~last_r);
  end

`ifdef MATMULT_ARB_TIMEOUT_EN
  logic [31:0] wait_cnt_r;

  // Counts cycles spent in WAIT; restarts on every entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_r <= 32'd0;
    end else if (state_r == ST_WAIT) begin
      wait_cnt_r <= wait_cnt_r + 32'd1;
    end else begin
      wait_cnt_r <= 32'd0;
    end
  end

  assign timeout_s = (state_r == ST_WAIT) && !mm_valid &&
                     (wait_cnt_r == 32'(TIMEOUT_CYCLES - 1));
`else
  // Watchdog absent: a non-negative limit can never fire.
  assign timeout_s = (TIMEOUT_CYCLES < 0);
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and per-cycle strobes. Arbitration also runs in DRAIN once the
  // core valid has dropped, so back-to-back operations take 8 cycles.
  always_comb begin
    state_nxt_s = state_r;
    arb_s       = 1'b0;
    capture_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        arb_s = 1'b1;
      end
      ST_ISSUE: begin
        state_nxt_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (mm_valid) begin
          capture_s   = 1'b1;
          state_nxt_s = ST_ACK;
        end else if (timeout_s) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_ACK: begin
        state_nxt_s = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!mm_valid) begin
          arb_s       = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
    if (arb_s && (elig0_s || elig1_s)) begin
      state_nxt_s = ST_ISSUE;
    end else begin
      state_nxt_s = state_nxt_s;
    end
    gnt1_s = arb_s & pick1_s;
    gnt0_s = arb_s & elig0_s & ~pick1_s;
  end

  // Grant bookkeeping, operand latch and core handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_r    <= 1'b1;
      owner_r   <= 1'b0;
      req0_ack  <= 1'b0;
      req1_ack  <= 1'b0;
      mm_ready  <= 1'b0;
      mm_accept <= 1'b0;
      mm_in_a   <= 576'd0;
      mm_in_b   <= 576'd0;
      err       <= 1'b0;
    end else begin
      req0_ack  <= gnt0_s;
      req1_ack  <= gnt1_s;
      mm_ready  <= (state_r == ST_ISSUE);
      mm_accept <= capture_s | timeout_s;
      err       <= err | timeout_s;
      if (gnt0_s || gnt1_s) begin
        last_r  <= gnt1_s;
        owner_r <= gnt1_s;
        mm_in_a <= gnt1_s ? req1_in_a : req0_in_a;
        mm_in_b <= gnt1_s ? req1_in_b : req0_in_b;
      end else begin
        last_r  <= last_r;
        owner_r <= owner_r;
      end
    end
  end

  // Per-requester result holding registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req0_valid <= 1'b0;
      req1_valid <= 1'b0;
      req0_out_c <= 576'd0;
      req1_out_c <= 576'd0;
    end else begin
      if (capture_s && !owner_r) begin
        req0_out_c <= mm_out_c;
        req0_valid <= 1'b1;
      end else if (req0_accept) begin
        req0_valid <= 1'b0;
      end else begin
        req0_valid <= req0_valid;
      end
      if (capture_s && owner_r) begin
        req1_out_c <= mm_out_c;
        req1_valid <= 1'b1;
      end else if (req1_accept) begin
        req1_valid <= 1'b0;
      end else begin
        req1_valid <= req1_valid;
      end
    end
  end

endmodule
